// File: rtl/inst_prefetch_if.sv
// Bundles the instruction-memory read handshake, the decode-side valid/ready
// port and the redirect controls of the instruction prefetch queue.
interface inst_prefetch_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [63:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [63:0]   inst_pc;
  logic          inst_ready;
  logic          jump_en;
  logic [63:0]   inst_addr;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, count,
    input  imem_ack, imem_rdata, inst_ready, jump_en, inst_addr
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, count,
    output imem_ack, imem_rdata, inst_ready, jump_en, inst_addr
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch front end: fetches 32-bit words over req/ack into a
// DEPTH-entry {pc, inst} FIFO for decode, with flush/redirect on jump_en.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  inst_prefetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   redir_pc_q, redir_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [63:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          head_valid;
  logic          push;
  logic          pop;
  logic [CW-1:0] occ_after;
  logic [63:0]   target;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.inst_ready;
  assign occ_after  = count_q + CW'(1) - CW'(pop);
  assign target     = bus.inst_addr & ~64'h3;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;

    if (bus.jump_en) begin
      // Flush everything; the popped head (the jump itself) is already gone.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      unique case (state_q)
        IDLE: begin
          fetch_pc_d = target;
          state_d    = WAIT;
        end
        WAIT, DROP: begin
          if (bus.imem_ack) begin
            fetch_pc_d = target;
            state_d    = WAIT;
          end else begin
            // Outstanding request keeps its stale address until acked.
            redir_pc_d = target;
            state_d    = DROP;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q < FULL) state_d = WAIT;
        end
        WAIT: begin
          if (bus.imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 64'd4;
            state_d    = (occ_after < FULL) ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            fetch_pc_d = redir_pc_q;
            state_d    = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = (state_q != IDLE);
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign bus.inst_pc    = head_valid ? pc_mem[rd_ptr_q]   : 64'h0;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: fetch streaming, back-pressure,
// redirect with and without a coincident ack, async reset and PC wrap.
module tb_inst_prefetch_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_prefetch_if #(.DEPTH(4)) bus ();

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(64'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory returns a word derived from the address so the pairing is checkable.
  assign bus.imem_rdata = bus.imem_addr[31:0] ^ 32'hFFFF_0000;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    bus.jump_en    = 1'b0;
    bus.inst_addr  = 64'h0;
    step();
    step();
    chk("rst_req",   64'(bus.imem_req),   64'h0);
    chk("rst_valid", 64'(bus.inst_valid), 64'h0);
    chk("rst_count", 64'(bus.count),      64'h0);
    chk("rst_inst",  64'(bus.inst),       64'h0);
    chk("rst_pc",    bus.inst_pc,         64'h0);
    chk("rst_addr",  bus.imem_addr,       64'h8000_0000);

    // Streaming: ack and ready held high
    bus.imem_ack   = 1'b1;
    bus.inst_ready = 1'b1;
    rst            = 1'b0;
    step();
    chk("t1_req",    64'(bus.imem_req),   64'h1);
    chk("t1_addr0",  bus.imem_addr,       64'h8000_0000);
    chk("t1_nvalid", 64'(bus.inst_valid), 64'h0);
    step();
    chk("t1_valid",  64'(bus.inst_valid), 64'h1);
    chk("t1_pc0",    bus.inst_pc,         64'h8000_0000);
    chk("t1_inst0",  64'(bus.inst),       64'h7FFF_0000);
    chk("t1_cnt",    64'(bus.count),      64'h1);
    step();
    chk("t1_pc1",    bus.inst_pc,         64'h8000_0004);
    chk("t1_inst1",  64'(bus.inst),       64'h7FFF_0004);
    step();
    chk("t1_pc2",    bus.inst_pc,         64'h8000_0008);
    chk("t1_cnt2",   64'(bus.count),      64'h1);

    // Back-pressure fills the FIFO and stops requests
    bus.inst_ready = 1'b0;
    step();
    step();
    step();
    chk("t2_full",   64'(bus.count),      64'h4);
    chk("t2_noreq",  64'(bus.imem_req),   64'h0);
    chk("t2_addr",   bus.imem_addr,       64'h8000_0018);
    chk("t2_head",   bus.inst_pc,         64'h8000_0008);
    step();
    chk("t2_idle",   64'(bus.imem_req),   64'h0);
    bus.inst_ready = 1'b1;
    step();
    chk("t2_pop",    64'(bus.count),      64'h3);
    chk("t2_head2",  bus.inst_pc,         64'h8000_000C);
    chk("t2_noreq2", 64'(bus.imem_req),   64'h0);
    bus.inst_ready = 1'b0;
    step();
    chk("t2_req",    64'(bus.imem_req),   64'h1);
    chk("t2_raddr",  bus.imem_addr,       64'h8000_0018);
    step();
    chk("t2_refull", 64'(bus.count),      64'h4);
    chk("t2_reidle", 64'(bus.imem_req),   64'h0);

    // Redirect while a request is outstanding without ack
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    chk("t3_cnt3",   64'(bus.count),      64'h3);
    step();
    chk("t3_req",    64'(bus.imem_req),   64'h1);
    chk("t3_addr",   bus.imem_addr,       64'h8000_001C);
    chk("t3_cnt2",   64'(bus.count),      64'h2);
    bus.inst_ready = 1'b0;
    bus.jump_en    = 1'b1;
    bus.inst_addr  = 64'h8000_0100;
    step();
    chk("t3_flush",  64'(bus.count),      64'h0);
    chk("t3_nvalid", 64'(bus.inst_valid), 64'h0);
    chk("t3_zpc",    bus.inst_pc,         64'h0);
    chk("t3_stale",  bus.imem_addr,       64'h8000_001C);
    chk("t3_dreq",   64'(bus.imem_req),   64'h1);
    bus.jump_en = 1'b0;
    step();
    chk("t3_stale2", bus.imem_addr,       64'h8000_001C);
    bus.imem_ack = 1'b1;
    step();
    chk("t3_drop",   64'(bus.count),      64'h0);
    chk("t3_naddr",  bus.imem_addr,       64'h8000_0100);
    step();
    chk("t3_valid",  64'(bus.inst_valid), 64'h1);
    chk("t3_pc",     bus.inst_pc,         64'h8000_0100);
    chk("t3_inst",   64'(bus.inst),       64'h7FFF_0100);

    // Redirect coinciding with an ack, three entries held
    step();
    step();
    chk("t4_cnt3",   64'(bus.count),      64'h3);
    bus.jump_en   = 1'b1;
    bus.inst_addr = 64'h8000_0300;
    step();
    chk("t4_flush",  64'(bus.count),      64'h0);
    chk("t4_addr",   bus.imem_addr,       64'h8000_0300);
    chk("t4_req",    64'(bus.imem_req),   64'h1);
    bus.jump_en = 1'b0;
    step();
    chk("t4_valid",  64'(bus.inst_valid), 64'h1);
    chk("t4_pc",     bus.inst_pc,         64'h8000_0300);
    chk("t4_next",   bus.imem_addr,       64'h8000_0304);

    // Misaligned target, then a long stall
    bus.jump_en   = 1'b1;
    bus.inst_addr = 64'h8000_0203;
    bus.imem_ack  = 1'b0;
    step();
    chk("t5_stale",  bus.imem_addr,       64'h8000_0304);
    bus.jump_en  = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    chk("t5_align",  bus.imem_addr,       64'h8000_0200);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_hreq",  64'(bus.imem_req),   64'h1);
      chk("t5_haddr", bus.imem_addr,       64'h8000_0200);
      chk("t5_hval",  64'(bus.inst_valid), 64'h0);
    end

    // Asynchronous reset while dropping a response
    bus.jump_en   = 1'b1;
    bus.inst_addr = 64'h8000_0400;
    step();
    chk("t6_drop",   bus.imem_addr,       64'h8000_0200);
    bus.jump_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_req",    64'(bus.imem_req),   64'h0);
    chk("t6_addr",   bus.imem_addr,       64'h8000_0000);
    chk("t6_cnt",    64'(bus.count),      64'h0);
    chk("t6_valid",  64'(bus.inst_valid), 64'h0);
    chk("t6_inst",   64'(bus.inst),       64'h0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    chk("t6_req2",   64'(bus.imem_req),   64'h1);
    chk("t6_addr2",  bus.imem_addr,       64'h8000_0000);
    step();
    chk("t6_pc",     bus.inst_pc,         64'h8000_0000);

    // PC wrap past 2^64
    bus.jump_en   = 1'b1;
    bus.inst_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("w_addr",    bus.imem_addr,       64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_flush",   64'(bus.count),      64'h0);
    bus.jump_en = 1'b0;
    step();
    chk("w_pc",      bus.inst_pc,         64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_inst",    64'(bus.inst),       64'h0000_FFFC);
    chk("w_wrap",    bus.imem_addr,       64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
